// File: rtl/vga_pkg.sv
// vga_pkg: shared pixel format, window slot indices and display timing constants
package vga_pkg;
  localparam int PIX_W = 12;
  localparam int R_HI = 11, R_LO = 8, G_HI = 7, G_LO = 4, B_HI = 3, B_LO = 0;
  localparam int WIN_TL = 0, WIN_TC = 1, WIN_TR = 2;
  localparam int WIN_ML = 3, WIN_MC = 4, WIN_MR = 5;
  localparam int WIN_BL = 6, WIN_BC = 7, WIN_BR = 8;
  localparam int H_ACTIVE = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
  localparam int V_ACTIVE = 480, V_FP = 10, V_SYNC = 2, V_BP = 33;
endpackage

// File: rtl/line_buffer.sv
// line_buffer: simple dual-port sync-read RAM holding one image line, read-first
module line_buffer #(
  parameter int DEPTH = 256,
  parameter int AW = 8,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/window_3x3_gen.sv
// window_3x3_gen: streaming 3x3 neighbourhood generator over two line buffers
module window_3x3_gen
  import vga_pkg::*;
#(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int CW = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               in_sof,
  input  logic [PIX_W-1:0]   in_data,
  output logic               out_valid,
  output logic [9*PIX_W-1:0] out_win,
  output logic [CW-1:0]      out_row,
  output logic [CW-1:0]      out_col,
  output logic               out_eof
);
  localparam int AW = $clog2(IMG_W);
  logic acc, s1_valid, s2_valid, s2_eof;
  logic [CW-1:0] col, row, pos_col, pos_row, s1_col, s1_row, s2_col, s2_row;
  logic [PIX_W-1:0] s1_pix, lb0_rd, lb1_rd;
  logic [PIX_W-1:0] w [3][3];
  logic [9*PIX_W-1:0] win_flat;
  assign acc = in_valid & ~reset;
  assign pos_col = in_sof ? '0 : col;
  assign pos_row = in_sof ? '0 : row;
  line_buffer #(.DEPTH(IMG_W), .AW(AW), .DW(PIX_W)) u_lb0 (
    .clk(clk), .we(acc), .waddr(pos_col[AW-1:0]), .wdata(in_data),
    .raddr(pos_col[AW-1:0]), .rdata(lb0_rd)
  );
  line_buffer #(.DEPTH(IMG_W), .AW(AW), .DW(PIX_W)) u_lb1 (
    .clk(clk), .we(s1_valid), .waddr(s1_col[AW-1:0]), .wdata(lb0_rd),
    .raddr(pos_col[AW-1:0]), .rdata(lb1_rd)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (acc) begin
      col <= (pos_col == CW'(IMG_W - 1)) ? '0 : pos_col + CW'(1);
      row <= (pos_col != CW'(IMG_W - 1)) ? pos_row :
             (pos_row == CW'(IMG_H - 1)) ? '0 : pos_row + CW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_eof <= 1'b0;
    end else begin
      s1_valid <= acc;
      s2_valid <= s1_valid && s1_row >= CW'(2) && s1_col >= CW'(2);
      s2_eof <= s1_row == CW'(IMG_H - 1) && s1_col == CW'(IMG_W - 1);
    end
  end
  always_ff @(posedge clk) begin
    if (acc) begin
      s1_col <= pos_col;
      s1_row <= pos_row;
      s1_pix <= in_data;
    end
    if (s1_valid) begin
      s2_row <= s1_row - CW'(1);
      s2_col <= s1_col - CW'(1);
      for (int i = 0; i < 3; i++) begin
        w[i][0] <= w[i][1];
        w[i][1] <= w[i][2];
      end
      w[0][2] <= lb1_rd;
      w[1][2] <= lb0_rd;
      w[2][2] <= s1_pix;
    end
  end
  for (genvar k = 0; k < 9; k++) begin : g_slot
    assign win_flat[k*PIX_W +: PIX_W] = w[k/3][k%3];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_eof <= 1'b0;
      out_win <= '0;
      out_row <= '0;
      out_col <= '0;
    end else begin
      out_valid <= s2_valid;
      out_eof <= s2_valid & s2_eof;
      if (s2_valid) begin
        out_win <= win_flat;
        out_row <= s2_row;
        out_col <= s2_col;
      end
    end
  end
endmodule

// File: tb/tb_window_3x3_gen.sv
// tb_window_3x3_gen: scoreboard bench for window_3x3_gen on an 8x6 image
module tb_window_3x3_gen;
  localparam int IMG_W = 8, IMG_H = 6, CW = 3;
  typedef struct {
    int due;
    logic [107:0] win;
    int row;
    int col;
    int eof;
  } exp_t;
  logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, in_sof = 1'b0;
  logic [11:0] in_data = '0;
  logic out_valid, out_eof;
  logic [107:0] out_win;
  logic [CW-1:0] out_row, out_col;
  exp_t q[$];
  logic [11:0] img [IMG_H][IMG_W];
  logic [107:0] last_win;
  int last_row, last_col;
  int checks = 0, errors = 0;
  int cyc = 0, mr = 0, mc = 0, nwin = 0, neof = 0, cur_off = 0, first_cyc = -1;
  window_3x3_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CW(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .out_valid(out_valid), .out_win(out_win), .out_row(out_row), .out_col(out_col),
    .out_eof(out_eof)
  );
  always #5 clk = ~clk;
  task automatic chki(input string tag, input int got, input int want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask
  task automatic chkw(input string tag, input logic [107:0] got, input logic [107:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %h want %h", tag, got, want);
    end
  endtask
  function automatic logic [11:0] pix(input int r, input int c, input int off);
    return {4'(r), 4'(c), 4'h0} + 12'(off);
  endfunction
  task automatic step(input bit v, input bit sof, input bit rst, input logic [11:0] d);
    int r, c;
    bit exp_v;
    exp_t e;
    in_valid = v;
    in_sof = sof;
    reset = rst;
    in_data = d;
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      mr = 0;
      mc = 0;
      last_win = '0;
      last_row = 0;
      last_col = 0;
    end else if (v) begin
      r = sof ? 0 : mr;
      c = sof ? 0 : mc;
      img[r][c] = d;
      if (r >= 2 && c >= 2) begin
        e.due = cyc + 2;
        for (int k = 0; k < 9; k++) e.win[k*12 +: 12] = img[r-2+k/3][c-2+k%3];
        e.row = r - 1;
        e.col = c - 1;
        e.eof = (r == IMG_H - 1 && c == IMG_W - 1) ? 1 : 0;
        q.push_back(e);
      end
      mc = (c == IMG_W - 1) ? 0 : c + 1;
      mr = (c != IMG_W - 1) ? r : (r == IMG_H - 1) ? 0 : r + 1;
    end
    @(negedge clk);
    exp_v = q.size() > 0 && q[0].due == cyc;
    chki("out_valid", int'(out_valid), int'(exp_v));
    if (exp_v) begin
      e = q.pop_front();
      chkw("win", out_win, e.win);
      chki("row", int'(out_row), e.row);
      chki("col", int'(out_col), e.col);
      chki("eof", int'(out_eof), e.eof);
      if (cur_off == 0 && e.row == 1 && e.col == 1) begin
        chki("first_win0", int'(out_win[0 +: 12]), 'h000);
        chki("first_win4", int'(out_win[48 +: 12]), 'h110);
        chki("first_win8", int'(out_win[96 +: 12]), 'h220);
      end
      if (cur_off == 0 && e.row == 2 && e.col == 1) begin
        chki("cross_win3", int'(out_win[36 +: 12]), 'h200);
        chki("cross_win5", int'(out_win[60 +: 12]), 'h220);
      end
      last_win = e.win;
      last_row = e.row;
      last_col = e.col;
      nwin++;
      neof += e.eof;
      if (first_cyc < 0) first_cyc = cyc;
    end else begin
      chkw("hold_win", out_win, last_win);
      chki("hold_row", int'(out_row), last_row);
      chki("hold_col", int'(out_col), last_col);
      chki("idle_eof", int'(out_eof), 0);
    end
  endtask
  task automatic run(input int n, input int off, input bit gap, input bit sof0);
    cur_off = off;
    for (int i = 0; i < n; i++) begin
      step(1'b1, sof0 && i == 0, 1'b0, pix((i / IMG_W) % IMG_H, i % IMG_W, off));
      if (gap) step(1'b0, 1'b0, 1'b0, 12'hfff);
    end
  endtask
  task automatic drain();
    repeat (4) step(1'b0, 1'b0, 1'b0, 12'h000);
    chki("queue_empty", q.size(), 0);
  endtask
  initial begin
    int rst_cyc;
    step(1'b0, 1'b0, 1'b1, 12'h000);
    step(1'b0, 1'b0, 1'b1, 12'h000);
    step(1'b0, 1'b0, 1'b0, 12'h000);
    nwin = 0; neof = 0;
    run(IMG_W * IMG_H, 0, 1'b0, 1'b1);
    drain();
    chki("t1_count", nwin, 24);
    chki("t1_eof_count", neof, 1);
    nwin = 0; neof = 0;
    run(IMG_W * IMG_H, 0, 1'b1, 1'b1);
    drain();
    chki("t2_count", nwin, 24);
    chki("t2_eof_count", neof, 1);
    nwin = 0; neof = 0;
    run(IMG_W * IMG_H, 0, 1'b0, 1'b1);
    run(IMG_W * IMG_H, 1, 1'b0, 1'b1);
    drain();
    chki("t4_count", nwin, 48);
    chki("t4_eof_count", neof, 2);
    cur_off = 0;
    run(3 * IMG_W + 4, 0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, pix(3, 4, 0));
    rst_cyc = cyc;
    nwin = 0; neof = 0; first_cyc = -1;
    run(IMG_W * IMG_H, 0, 1'b0, 1'b0);
    drain();
    chki("t5_first_latency", first_cyc - rst_cyc, 21);
    chki("t5_count", nwin, 24);
    nwin = 0; neof = 0;
    run(3 * IMG_W + 5, 0, 1'b0, 1'b1);
    run(IMG_W * IMG_H, 0, 1'b0, 1'b1);
    drain();
    chki("t6_count", nwin, 33);
    chki("t6_eof_count", neof, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
